pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/pc_gen_if.sv | 30 +++
 rtl/pc_event_arbiter.sv | 49 ++++
 rtl/pc_gen.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types for the PC generator: FSM states and the event-select encoding.
package pc_gen_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned DEFAULT_STEP = 4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_TRAP  = 2'd1,
    EVT_MRET  = 2'd2,
    EVT_REDIR = 2'd3
  } evt_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control-flow event inputs and fetch-request handshake of the PC generator.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            halt_req;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vec;
  logic [XLEN-1:0] trap_pc;
  logic            mret_valid;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] epc;
  logic            misalign_err;

  modport master (
    input  stall, halt_req, redirect_valid, redirect_addr,
    input  trap_valid, trap_vec, trap_pc, mret_valid, fetch_ready,
    output fetch_valid, pc, epc, misalign_err
  );

  modport slave (
    output stall, halt_req, redirect_valid, redirect_addr,
    output trap_valid, trap_vec, trap_pc, mret_valid, fetch_ready,
    input  fetch_valid, pc, epc, misalign_err
  );
endinterface

// File: rtl/pc_event_arbiter.sv
// Picks the winning control-flow event (trap > mret > redirect) and checks
// redirect alignment; purely combinational.
module pc_event_arbiter
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN,
  parameter int unsigned STEP = DEFAULT_STEP
) (
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] epc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            evt_valid_c,
  output evt_sel_e        evt_sel_c,
  output logic [XLEN-1:0] evt_target_c,
  output logic            misalign_c
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  logic redir_aligned;
  assign redir_aligned = (redirect_addr & ALIGN_MASK) == '0;

  // A misaligned redirect only reports an error when it would have won.
  always_comb begin
    evt_sel_c    = EVT_NONE;
    evt_target_c = '0;
    misalign_c   = 1'b0;
    if (trap_valid) begin
      evt_sel_c    = EVT_TRAP;
      evt_target_c = trap_vec & ~ALIGN_MASK;
    end else if (mret_valid) begin
      evt_sel_c    = EVT_MRET;
      evt_target_c = epc;
    end else if (redirect_valid) begin
      if (redir_aligned) begin
        evt_sel_c    = EVT_REDIR;
        evt_target_c = redirect_addr;
      end else begin
        misalign_c = 1'b1;
      end
    end
  end

  assign evt_valid_c = evt_sel_c != EVT_NONE;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch addresses, redirect/trap/mret
// handling with a one-entry pending target, and a BOOT/RUN/HALT FSM.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
  parameter int unsigned          STEP         = DEFAULT_STEP
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_gen_if.master  bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pend_valid_q, pend_valid_d;
  logic            halt_pend_q, halt_pend_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            misalign_err_q, misalign_err_d;

  logic            evt_valid_c;
  evt_sel_e        evt_sel_c;
  logic [XLEN-1:0] evt_target_c;
  logic            misalign_c;
  logic            fire_c;
  logic            hold_c;

  pc_event_arbiter #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_arb (
    .trap_valid     (bus.trap_valid),
    .trap_vec       (bus.trap_vec),
    .mret_valid     (bus.mret_valid),
    .epc            (epc_q),
    .redirect_valid (bus.redirect_valid),
    .redirect_addr  (bus.redirect_addr),
    .evt_valid_c    (evt_valid_c),
    .evt_sel_c      (evt_sel_c),
    .evt_target_c   (evt_target_c),
    .misalign_c     (misalign_c)
  );

  assign fire_c = fetch_valid_q && bus.fetch_ready;
  assign hold_c = fetch_valid_q && !bus.fetch_ready;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    epc_d          = epc_q;
    pend_addr_d    = pend_addr_q;
    pend_valid_d   = pend_valid_q;
    halt_pend_d    = halt_pend_q;
    misalign_err_d = misalign_c;

    if (evt_sel_c == EVT_TRAP) epc_d = bus.trap_pc;

    // An outstanding request must keep its pc, so park the target instead.
    if (evt_valid_c) begin
      if (hold_c) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = evt_target_c;
      end else begin
        pc_d         = evt_target_c;
        pend_valid_d = 1'b0;
      end
    end else if (fire_c) begin
      if (pend_valid_q) begin
        pc_d         = pend_addr_q;
        pend_valid_d = 1'b0;
      end else begin
        pc_d = pc_q + XLEN'(STEP);
      end
    end

    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.halt_req) halt_pend_d = 1'b1;
        if ((bus.halt_req || halt_pend_q) && !hold_c) begin
          state_d     = ST_HALT;
          halt_pend_d = 1'b0;
        end
      end
      ST_HALT: if (evt_valid_c) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    fetch_valid_d = (state_d == ST_RUN) && (!bus.stall || hold_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      epc_q          <= '0;
      pend_addr_q    <= '0;
      pend_valid_q   <= 1'b0;
      halt_pend_q    <= 1'b0;
      fetch_valid_q  <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      epc_q          <= epc_d;
      pend_addr_q    <= pend_addr_d;
      pend_valid_q   <= pend_valid_d;
      halt_pend_q    <= halt_pend_d;
      fetch_valid_q  <= fetch_valid_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  assign bus.fetch_valid  = fetch_valid_q;
  assign bus.pc           = pc_q;
  assign bus.epc          = epc_q;
  assign bus.misalign_err = misalign_err_q;

endmodule
